// File: rtl/hsl_pkg.sv
// Shared definitions for the RGB/HSL colour-space converters: FSM state encoding and
// default channel depths.
package hsl_pkg;

  localparam int unsigned DefHueDepth = 8;
  localparam int unsigned DefSatDepth = 8;
  localparam int unsigned DefRgbDepth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StDivS,
    StDivH,
    StDone
  } hsl_state_e;

  // Counter width able to hold the value n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle. The caller guarantees dividend < divisor
// (or divisor == 0, which yields all-ones), and zeros are shifted in for `steps` cycles.
module seq_divider #(
  parameter int unsigned Width    = 11,
  parameter int unsigned QuoWidth = 9,
  parameter int unsigned CntWidth = $clog2(QuoWidth + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [Width-1:0]    dividend,
  input  logic [Width-1:0]    divisor,
  input  logic [CntWidth-1:0] steps,
  output logic                done,
  output logic [QuoWidth-1:0] quotient
);

  logic [Width-1:0]    rem_q, rem_d;
  logic [Width-1:0]    dsr_q, dsr_d;
  logic [QuoWidth-1:0] quo_q, quo_d, quo_step;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [Width:0]      rem_shift, rem_sub;
  logic                fits;
  logic                busy;

  always_comb begin
    rem_shift = {rem_q, 1'b0};
    fits      = rem_shift >= {1'b0, dsr_q};
    rem_sub   = rem_shift - {1'b0, dsr_q};
    quo_step  = {quo_q[QuoWidth-2:0], fits};
  end

  assign busy     = cnt_q != '0;
  // Quotient is presented combinationally during the final step so the caller can
  // capture it and restart the divider on the same edge.
  assign done     = cnt_q == CntWidth'(1);
  assign quotient = quo_step;

  always_comb begin
    rem_d = rem_q;
    dsr_d = dsr_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    if (start) begin
      rem_d = dividend;
      dsr_d = divisor;
      quo_d = '0;
      cnt_d = steps;
    end else if (busy) begin
      rem_d = fits ? rem_sub[Width-1:0] : rem_shift[Width-1:0];
      quo_d = quo_step;
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      dsr_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgb_to_hsl.sv
// Sequential RGB to HSL converter. Saturation and hue are produced by one shared
// restoring divider; results are held in DONE until the consumer takes them.
module rgb_to_hsl
  import hsl_pkg::*;
#(
  parameter int unsigned HUE_DEPTH = DefHueDepth,
  parameter int unsigned SAT_DEPTH = DefSatDepth,
  parameter int unsigned RGB_DEPTH = DefRgbDepth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RGB_DEPTH-1:0] r,
  input  logic [RGB_DEPTH-1:0] g,
  input  logic [RGB_DEPTH-1:0] b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [HUE_DEPTH-1:0] h,
  output logic [SAT_DEPTH-1:0] s,
  output logic [RGB_DEPTH-1:0] l,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // 6C and the hue numerator need RGB_DEPTH+3 bits; the signed form one more.
  localparam int unsigned NumWidth = RGB_DEPTH + 3;
  localparam int unsigned SgnWidth = RGB_DEPTH + 4;
  localparam int unsigned QuoWidth = (SAT_DEPTH + 1 > HUE_DEPTH) ? SAT_DEPTH + 1 : HUE_DEPTH;
  localparam int unsigned CntWidth = cnt_width(QuoWidth);

  hsl_state_e state_q, state_d;

  logic [RGB_DEPTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [RGB_DEPTH-1:0] c_q, c_d;
  logic [NumWidth-1:0]  num_q, num_d;
  logic [HUE_DEPTH-1:0] h_q, h_d;
  logic [SAT_DEPTH-1:0] s_q, s_d;
  logic [RGB_DEPTH-1:0] l_q, l_d;

  logic                 r_max, g_max;
  logic [RGB_DEPTH-1:0] max_v, min_v, c_v, l_v;
  logic [RGB_DEPTH:0]   sum_v, l_dbl, l2_v;
  logic signed [SgnWidth-1:0] rs, gs, bs, cs, c6s, n_raw, n_adj;
  logic [NumWidth-1:0]  num_v, c6_hue;

  logic                 div_start, div_done;
  logic [NumWidth-1:0]  div_dividend, div_divisor;
  logic [CntWidth-1:0]  div_steps;
  logic [QuoWidth-1:0]  div_quotient;
  logic [SAT_DEPTH:0]   sat_raw;
  logic [SAT_DEPTH-1:0] sat_v;

  // Colour statistics from the registered sample, consumed in PREP.
  always_comb begin
    min_v = (r_q <= g_q) ? r_q : g_q;
    if (b_q < min_v) min_v = b_q;
    r_max = (r_q >= g_q) && (r_q >= b_q);
    g_max = !r_max && (g_q >= b_q);
    max_v = r_max ? r_q : (g_max ? g_q : b_q);
    c_v   = max_v - min_v;
    sum_v = {1'b0, max_v} + {1'b0, min_v};
    l_v   = sum_v[RGB_DEPTH:1];
    l_dbl = {l_v, 1'b0};
    // Upper half: 2^(RGB_DEPTH+1) - 2l, i.e. two's complement in RGB_DEPTH+1 bits.
    l2_v  = l_v[RGB_DEPTH-1] ? ({(RGB_DEPTH + 1){1'b0}} - l_dbl) : l_dbl;

    rs  = SgnWidth'(r_q);
    gs  = SgnWidth'(g_q);
    bs  = SgnWidth'(b_q);
    cs  = SgnWidth'(c_v);
    c6s = (cs <<< 2) + (cs <<< 1);
    if (r_max)      n_raw = gs - bs;
    else if (g_max) n_raw = (cs <<< 1) + bs - rs;
    else            n_raw = (cs <<< 2) + rs - gs;
    n_adj = (n_raw < 0) ? n_raw + c6s : n_raw;
    num_v = n_adj[NumWidth-1:0];
  end

  assign c6_hue  = (NumWidth'(c_q) << 2) + (NumWidth'(c_q) << 1);
  assign sat_raw = div_quotient[SAT_DEPTH:0];
  assign sat_v   = sat_raw[SAT_DEPTH] ? {SAT_DEPTH{1'b1}} : sat_raw[SAT_DEPTH-1:0];

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    c_d          = c_q;
    num_d        = num_q;
    h_d          = h_q;
    s_d          = s_q;
    l_d          = l_q;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    div_steps    = '0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          r_d     = r;
          g_d     = g;
          b_d     = b;
          state_d = StPrep;
        end
      end
      StPrep: begin
        l_d   = l_v;
        c_d   = c_v;
        num_d = num_v;
        if (c_v == '0) begin
          h_d     = '0;
          s_d     = '0;
          state_d = StDone;
        end else begin
          // C*2^S/L2 computed as C*2^(S+1)/(2*L2) so only zeros are shifted in.
          div_start    = 1'b1;
          div_dividend = NumWidth'(c_v);
          div_divisor  = NumWidth'({l2_v, 1'b0});
          div_steps    = CntWidth'(SAT_DEPTH + 1);
          state_d      = StDivS;
        end
      end
      StDivS: begin
        if (div_done) begin
          s_d          = sat_v;
          div_start    = 1'b1;
          div_dividend = num_q;
          div_divisor  = c6_hue;
          div_steps    = CntWidth'(HUE_DEPTH);
          state_d      = StDivH;
        end
      end
      StDivH: begin
        if (div_done) begin
          h_d     = div_quotient[HUE_DEPTH-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      num_q   <= '0;
      h_q     <= '0;
      s_q     <= '0;
      l_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      c_q     <= c_d;
      num_q   <= num_d;
      h_q     <= h_d;
      s_q     <= s_d;
      l_q     <= l_d;
    end
  end

  seq_divider #(
    .Width   (NumWidth),
    .QuoWidth(QuoWidth),
    .CntWidth(CntWidth)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (div_divisor),
    .steps   (div_steps),
    .done    (div_done),
    .quotient(div_quotient)
  );

  assign in_ready  = state_q == StIdle;
  assign out_valid = state_q == StDone;
  assign h         = h_q;
  assign s         = s_q;
  assign l         = l_q;

endmodule

// File: tb/tb_rgb_to_hsl.sv
// Self-checking bench for rgb_to_hsl at 8-bit depths: directed corner colours, handshake
// hold, reset abort, randomized colours and an HSL->RGB->HSL round trip.
module tb_rgb_to_hsl;

  localparam int Depth = 8;
  localparam int Full  = 1 << Depth;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] r = '0, g = '0, b = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid;
  logic [7:0] h, s, l;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  rgb_to_hsl #(
    .HUE_DEPTH(Depth),
    .SAT_DEPTH(Depth),
    .RGB_DEPTH(Depth)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .r        (r),
    .g        (g),
    .b        (b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .h        (h),
    .s        (s),
    .l        (l),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
    int d;
    d = got - exp;
    if (d < 0) d = -d;
    n_vec++;
    if (d > tol) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", tag, got, exp, tol);
    end
  endtask

  // Reference straight from the HSL definitions, integer arithmetic, truncating.
  function automatic void ref_hsl(input int rr, input int gg, input int bb,
                                  output int eh, output int es, output int el,
                                  output int elat);
    int mx, mn, c, l2, n;
    mx = rr; if (gg > mx) mx = gg; if (bb > mx) mx = bb;
    mn = rr; if (gg < mn) mn = gg; if (bb < mn) mn = bb;
    c  = mx - mn;
    el = (mx + mn) / 2;
    l2 = (el >= Full / 2) ? 2 * Full - 2 * el : 2 * el;
    if (c == 0) begin
      eh = 0; es = 0; elat = 2;
      return;
    end
    elat = 2 * Depth + 3;
    es = (l2 == 0) ? Full - 1 : (c * Full) / l2;
    if (es > Full - 1) es = Full - 1;
    if (rr == mx)      n = gg - bb;
    else if (gg == mx) n = 2 * c + bb - rr;
    else               n = 4 * c + rr - gg;
    if (n < 0) n += 6 * c;
    eh = (n * Full) / (6 * c);
  endfunction

  // Behavioural HSL->RGB used to build round-trip stimulus.
  function automatic void hsl2rgb(input int hh, input int ss, input int ll,
                                  output int rr, output int gg, output int bb);
    int l2, cc, mx, mn, x, k, t;
    l2 = (ll >= Full / 2) ? 2 * Full - 2 * ll : 2 * ll;
    cc = ss * l2 / Full;
    mx = ll + (cc - cc / 2);
    mn = ll - cc / 2;
    x  = hh * 6;
    k  = x / Full;
    t  = (x - k * Full) * cc / Full;
    case (k)
      0:       begin rr = mx;     gg = mn + t; bb = mn;     end
      1:       begin rr = mx - t; gg = mx;     bb = mn;     end
      2:       begin rr = mn;     gg = mx;     bb = mn + t; end
      3:       begin rr = mn;     gg = mx - t; bb = mx;     end
      4:       begin rr = mn + t; gg = mn;     bb = mx;     end
      default: begin rr = mx;     gg = mn;     bb = mx - t; end
    endcase
  endfunction

  function automatic int pick(input int shared);
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       return 0;
      1:       return Full - 1;
      2:       return shared;
      default: return $urandom_range(0, Full - 1);
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge where out_valid is first seen.
  // Latency counts falling edges, the one right after the accepting edge being 1.
  task automatic convert(input int rr, input int gg, input int bb,
                         output int oh, output int os, output int ol, output int olat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    r = 8'(rr); g = 8'(gg); b = 8'(bb);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    olat = 1;
    while (!out_valid && olat < 100) begin
      @(negedge clk);
      olat++;
    end
    oh = int'(h); os = int'(s); ol = int'(l);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_out_ready", int'(in_ready), 1);
  endtask

  task automatic check_vec(input string tag, input int rr, input int gg, input int bb);
    int oh, os, ol, olat, eh, es, el, elat;
    convert(rr, gg, bb, oh, os, ol, olat);
    ref_hsl(rr, gg, bb, eh, es, el, elat);
    chk({tag, "_lat"}, olat, elat);
    chk({tag, "_h"}, oh, eh);
    chk({tag, "_s"}, os, es);
    chk({tag, "_l"}, ol, el);
    release_out();
  endtask

  // r, g, b, expected h, s, l, latency
  localparam int Dir [6][7] = '{
    '{255,   0,   0,   0, 255, 127, 19},
    '{  0, 255,   0,  85, 255, 127, 19},
    '{  0,   0, 255, 170, 255, 127, 19},
    '{255,   0,   1, 255, 255, 127, 19},
    '{200, 100, 100,   0, 120, 150, 19},
    '{100, 100, 100,   0,   0, 100,  2}
  };

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int oh, os, ol, olat, eh, es, el, elat, cnt;
    int hh, ss, ll, rr, gg, bb, dh, sh;

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_h", int'(h), 0);
    chk("rst_s", int'(s), 0);
    chk("rst_l", int'(l), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(in_ready), 1);

    // Directed corner colours with literal expectations.
    for (int i = 0; i < 6; i++) begin
      convert(Dir[i][0], Dir[i][1], Dir[i][2], oh, os, ol, olat);
      chk($sformatf("dir%0d_h", i), oh, Dir[i][3]);
      chk($sformatf("dir%0d_s", i), os, Dir[i][4]);
      chk($sformatf("dir%0d_l", i), ol, Dir[i][5]);
      chk($sformatf("dir%0d_lat", i), olat, Dir[i][6]);
      release_out();
    end

    // Consumer stalls five cycles in DONE while a new sample is offered.
    convert(10, 200, 50, oh, os, ol, olat);
    ref_hsl(10, 200, 50, eh, es, el, elat);
    chk("stall_h", oh, eh);
    chk("stall_s", os, es);
    chk("stall_l", ol, el);
    r = 8'd1; g = 8'd2; b = 8'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_h_hold", int'(h), oh);
      chk("stall_s_hold", int'(s), os);
      chk("stall_l_hold", int'(l), ol);
    end
    in_valid = 1'b0;
    release_out();

    // Reset pulsed in the middle of the saturation division.
    r = 8'd180; g = 8'd40; b = 8'd90;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_h", int'(h), 0);
    chk("abort_s", int'(s), 0);
    chk("abort_l", int'(l), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("abort_no_output", cnt, 0);
    check_vec("after_abort", 180, 40, 90);

    // Randomized colours with ties and extremes mixed in.
    for (int i = 0; i < 150; i++) begin
      int shv;
      shv = $urandom_range(0, Full - 1);
      check_vec("rand", pick(shv), pick(shv), pick(shv));
    end

    // Round trip through a behavioural HSL->RGB converter.
    for (int i = 0; i < 60; i++) begin
      hh = $urandom_range(0, Full - 1);
      ss = $urandom_range(64, 240);
      ll = $urandom_range(96, 159);
      hsl2rgb(hh, ss, ll, rr, gg, bb);
      convert(rr, gg, bb, oh, os, ol, olat);
      ref_hsl(rr, gg, bb, eh, es, el, elat);
      chk("rt_exact_h", oh, eh);
      chk("rt_exact_s", os, es);
      chk("rt_l", ol, ll);
      sh = os;
      chk("rt_s", sh, ss, 2);
      dh = oh - hh;
      if (dh > Full / 2)  dh -= Full;
      if (dh < -Full / 2) dh += Full;
      chk("rt_h", hh + dh, hh, 2);
      release_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
